mux32_rr_arbiter: RTL and testbench
===================================

Name: mux32_rr_arbiter

Overview:
Round-robin arbiter that shares one 32:1 single-bit select path among 32 requesters. It drives the 5-bit select bus of the 32:1 mux tree and a registered one-hot grant vector. Each grant is bounded by a hold limit so that no requester can starve the others. It sits directly upstream of the mux, and its sel output connects straight to the mux select input.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one grant may be held; legal range 1..255.
HCW, $clog2(MAX_HOLD+1), width of the internal hold counter (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = new grants permitted; 0 = current grant may finish, no new grant issued
req  input  32  request vector; bit i = requester i wants the mux
release  input  1  current owner ends its grant this cycle
sel  output  5  registered index of current owner; drives the mux select
gnt_valid  output  1  registered; 1 = sel holds a live grant
gnt  output  32  registered one-hot grant; all zeros when gnt_valid=0
hold_cnt  output  HCW  cycles the current grant has been held (1..MAX_HOLD); 0 when idle

Behaviour:
- Reset (async, rst_n=0): sel=0, gnt_valid=0, gnt=0, hold_cnt=0, internal search pointer ptr=0, state=IDLE. Deassertion is taken synchronously by the first following edge.
- States: IDLE (no owner) and OWN (gnt_valid=1).
- Winner search (combinational): scan indices ptr, ptr+1, ..., ptr+31, all mod 32. The first index with req=1 wins.
  - ptr is last_granted+1 mod 32. Index 31+1 wraps to 0.
- IDLE:
  - If en=1 and |req on edge t: go to OWN, sel=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=1, ptr=winner+1.
  - Grant is visible in the cycle after edge t. Latency from request to grant is 1 clock.
- OWN, termination condition T on an edge: req[sel]=0 OR release=1 OR hold_cnt==MAX_HOLD.
  - Not T: hold_cnt increments; all other outputs are held.
  - T with en=1 and a winner found: switch on the same edge (back-to-back, no idle bubble). Load the new winner, hold_cnt=1, ptr=winner+1.
    - The search starts at the current sel+1, so the terminating owner is considered last.
    - If the terminating owner is the only requester, it is re-granted with hold_cnt=1.
  - T with en=0, or no requester: go to IDLE. gnt_valid=0, gnt=0, hold_cnt=0. sel keeps its last value; ptr is unchanged.
- en=0 never truncates a live grant early. It only blocks new or renewed grants.
- Requests are level-sensitive and not latched. A request dropped before it is granted is lost.
- sel, gnt and gnt_valid change only on clock edges (glitch-free mux select).
- Invariants:
  - gnt == (gnt_valid ? 1<<sel : 0).
  - hold_cnt <= MAX_HOLD.
  - gnt is one-hot or zero.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). The pointer returns to 0.

Test Plan:
1. Reset and single request: rst_n=0, then release reset; req=32'h0000_0010, en=1. Required: one cycle after the first sampled edge, gnt_valid=1, sel=4, gnt=32'h10, hold_cnt=1. Drop req. Next cycle: gnt_valid=0, gnt=0, hold_cnt=0.
2. Round-robin fairness with wrap: req=32'h8000_0003 held constant, release pulsed every grant. Required grant order is 0, 1, 31, 0, 1, 31, with back-to-back switches and no idle cycles.
3. Hold limit, MAX_HOLD=8: req=32'h0000_0021 held constant, no release. Required: sel=0 for exactly 8 cycles (hold_cnt 1..8), then sel=5 for 8 cycles, then sel=0 again.
4. Sole requester renewal: req=32'h0000_0200 held constant for 20 cycles. Required: sel=9 throughout, gnt_valid never drops, hold_cnt runs 1..8, 1..8, 1..4.
5. en gating: owner is 3 with hold_cnt=2; en=0; req=32'h0000_0108 held; release pulsed. Required: next cycle gnt_valid=0, no new grant while en=0. After en=1, requester 8 is granted 1 cycle later (ptr=4).
6. Async reset mid-grant: rst_n=0 between clock edges while sel=17. Required: sel=0, gnt=0, gnt_valid=0, hold_cnt=0 before the next edge. After release with req=32'hFFFF_FFFF, the first grant is to index 0.

Source files
------------

// File: rtl/mux32_rr_arbiter_if.sv
// Grant/request bundle between the round-robin arbiter (master side) and the
// requesters plus the 32:1 mux it steers (slave side).
interface mux32_rr_arbiter_if #(
  parameter  int MAX_HOLD = 8,
  localparam int HCW      = $clog2(MAX_HOLD + 1)
);
  logic           en;
  logic [31:0]    req;
  logic           release_grant;
  logic [4:0]     sel;
  logic           gnt_valid;
  logic [31:0]    gnt;
  logic [HCW-1:0] hold_cnt;

  modport master (
    input  en, req, release_grant,
    output sel, gnt_valid, gnt, hold_cnt
  );

  modport slave (
    output en, req, release_grant,
    input  sel, gnt_valid, gnt, hold_cnt
  );
endinterface

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter for a shared 32:1 mux: registered select/one-hot grant,
// each grant bounded to MAX_HOLD consecutive cycles.
module mux32_rr_arbiter #(
  parameter  int MAX_HOLD = 8,
  localparam int HCW      = $clog2(MAX_HOLD + 1)
) (
  input logic               clk,
  input logic               rst_n,
  mux32_rr_arbiter_if.master bus
);

  typedef enum logic {IDLE, OWN} state_e;

  state_e         state_q, state_d;
  logic [4:0]     sel_q, sel_d;
  logic [4:0]     ptr_q, ptr_d;
  logic [31:0]    gnt_q, gnt_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic       found;
  logic [4:0] winner;
  logic [4:0] idx;
  logic       term;

  // Scan from the far end so the index closest to ptr is the last to overwrite.
  always_comb begin
    found  = |bus.req;
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr_q + 5'(i);
      if (bus.req[idx]) winner = idx;
    end
  end

  assign term = !bus.req[sel_q] || bus.release_grant ||
                (hold_cnt_q == HCW'(MAX_HOLD));

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en && found) begin
          state_d    = OWN;
          sel_d      = winner;
          gnt_d      = 32'd1 << winner;
          hold_cnt_d = HCW'(1);
          ptr_d      = winner + 5'd1;
        end
      end
      OWN: begin
        if (!term) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end else if (bus.en && found) begin
          sel_d      = winner;
          gnt_d      = 32'd1 << winner;
          hold_cnt_d = HCW'(1);
          ptr_d      = winner + 5'd1;
        end else begin
          // sel and ptr stay put so the next search still starts after the last owner.
          state_d    = IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    bus.sel       = sel_q;
    bus.gnt       = gnt_q;
    bus.gnt_valid = (state_q == OWN);
    bus.hold_cnt  = hold_cnt_q;
  end

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed bench for mux32_rr_arbiter: reset, wrap-around fairness, hold limit,
// sole-requester renewal, enable gating and asynchronous reset mid-grant.
module tb_mux32_rr_arbiter;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  mux32_rr_arbiter_if #(.MAX_HOLD(8)) bus ();

  mux32_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_grant(input string tag, input int exp_sel, input int exp_hc);
    logic [31:0] exp_gnt;
    exp_gnt = 32'd1 << exp_sel;
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'd1);
    check({tag, ".sel"},       32'(bus.sel),       32'(exp_sel));
    check({tag, ".gnt"},       bus.gnt,            exp_gnt);
    check({tag, ".hold_cnt"},  32'(bus.hold_cnt),  32'(exp_hc));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'd0);
    check({tag, ".gnt"},       bus.gnt,            32'd0);
    check({tag, ".hold_cnt"},  32'(bus.hold_cnt),  32'd0);
  endtask

  // Outputs are sampled 1 ns after the rising edge, inputs driven at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    passed            = 0;
    total             = 0;
    rst_n             = 1'b0;
    bus.en            = 1'b0;
    bus.req           = '0;
    bus.release_grant = 1'b0;
    #12;
    check_idle("reset");
    check("reset.sel", 32'(bus.sel), 32'd0);

    // 1: single request, then drop
    rst_n   = 1'b1;
    bus.en  = 1'b1;
    bus.req = 32'h0000_0010;
    tick();
    check_grant("t1.grant", 4, 1);
    bus.req = '0;
    tick();
    check_idle("t1.drop");
    check("t1.sel_kept", 32'(bus.sel), 32'd4);

    // 2: fairness with wrap, release every cycle
    pulse_reset();
    bus.req           = 32'h8000_0003;
    bus.release_grant = 1'b1;
    tick(); check_grant("t2.g0", 0, 1);
    tick(); check_grant("t2.g1", 1, 1);
    tick(); check_grant("t2.g2", 31, 1);
    tick(); check_grant("t2.g3", 0, 1);
    tick(); check_grant("t2.g4", 1, 1);
    tick(); check_grant("t2.g5", 31, 1);
    bus.release_grant = 1'b0;
    bus.req           = '0;
    tick();
    check_idle("t2.end");

    // 3: hold limit with two requesters (ptr is 0 after the 31 grant)
    bus.req = 32'h0000_0021;
    for (int i = 1; i <= 8; i++) begin
      tick(); check_grant($sformatf("t3.own0_%0d", i), 0, i);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(); check_grant($sformatf("t3.own5_%0d", i), 5, i);
    end
    tick(); check_grant("t3.back0", 0, 1);
    bus.req = '0;
    tick();
    check_idle("t3.end");

    // 4: sole requester is renewed without a bubble
    bus.req = 32'h0000_0200;
    for (int k = 0; k < 20; k++) begin
      tick(); check_grant($sformatf("t4.c%0d", k), 9, (k % 8) + 1);
    end
    bus.req = '0;
    tick();
    check_idle("t4.end");

    // 5: en gating (ptr is 10, so 3 wins ahead of 8)
    bus.req = 32'h0000_0108;
    tick(); check_grant("t5.own3_1", 3, 1);
    tick(); check_grant("t5.own3_2", 3, 2);
    bus.en = 1'b0;
    tick(); check_grant("t5.en0_continues", 3, 3);
    bus.release_grant = 1'b1;
    tick();
    check_idle("t5.released");
    check("t5.sel_kept", 32'(bus.sel), 32'd3);
    bus.release_grant = 1'b0;
    tick(); check_idle("t5.blocked1");
    tick(); check_idle("t5.blocked2");
    bus.en = 1'b1;
    tick(); check_grant("t5.grant8", 8, 1);

    // 6: async reset while 17 owns
    bus.req = 32'h0002_0000;
    tick(); check_grant("t6.own17_1", 17, 1);
    tick(); check_grant("t6.own17_2", 17, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t6.async");
    check("t6.async.sel", 32'(bus.sel), 32'd0);
    bus.req = 32'hFFFF_FFFF;
    rst_n   = 1'b1;
    tick(); check_grant("t6.first", 0, 1);
    bus.release_grant = 1'b1;
    tick(); check_grant("t6.second", 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
